// File: rtl/input_cond_pkg.sv
// input_cond_pkg: shared constants and helpers for the input conditioner.
// Optional feature macro used by the design: INPUT_COND_PRESS_CNT_EN.
package input_cond_pkg;

    // Channel mapping on the LogiPi board
    localparam int CH_PB0 = 0;
    localparam int CH_PB1 = 1;
    localparam int CH_SW0 = 2;
    localparam int CH_SW1 = 3;

    localparam int N_CH_DEFAULT        = 4;
    localparam int DEBOUNCE_10MS_50MHZ = 500000;
    localparam int PRESS_CNT_W         = 2;

    // Debounce counter width: clog2 of the cycle count, never below one bit
    function automatic int cnt_width(input int cycles);
        int w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/input_conditioner_debounce_ch.sv
// debounce_ch: one input channel -- 2-flop synchroniser, debounce counter,
// stable-state register, registered edge pulses and, when
// INPUT_COND_PRESS_CNT_EN is defined, a wrapping 2-bit press counter.
module debounce_ch
    import input_cond_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ,
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_raw,
    output logic                   o_clean,
    output logic                   o_rise,
    output logic                   o_fall,
    output logic [PRESS_CNT_W-1:0] o_press_cnt
);

    localparam int               CNT_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             r_rise;
    logic             r_fall;
    logic             w_diff;
    logic             w_accept;

    // The synchronised level disagrees with the accepted level; once the
    // disagreement has lasted the full count, the new level is accepted.
    assign w_diff   = (r_sync2 != r_stable);
    assign w_accept = w_diff && (r_cnt == CNT_MAX);

    // Synchroniser, saturating debounce counter, stable level and edge pulses
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1  <= RESET_LEVEL;
            r_sync2  <= RESET_LEVEL;
            r_stable <= RESET_LEVEL;
            r_cnt    <= '0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            if (!w_diff) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
                r_rise   <= r_sync2;
                r_fall   <= !r_sync2;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

`ifdef INPUT_COND_PRESS_CNT_EN
    logic [PRESS_CNT_W-1:0] r_press;

    // Count accepted rising edges; wraps naturally at the counter width
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_press <= '0;
        end else if (w_accept && r_sync2) begin
            r_press <= r_press + PRESS_CNT_W'(1);
        end
    end

    assign o_press_cnt = r_press;
`else
    assign o_press_cnt = '0;
`endif

    assign o_clean = r_stable;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: synchronises, debounces and edge-detects N_CH raw
// button/switch pins. Press counters exist only when INPUT_COND_PRESS_CNT_EN
// is defined; otherwise PRESS_CNT is tied to zero with the same port list.
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int   N_CH            = N_CH_DEFAULT,
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ,
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic                          OSC_FPGA,
    input  logic                          RST,
    input  logic [N_CH-1:0]               RAW_IN,
    output logic [N_CH-1:0]               CLEAN,
    output logic [N_CH-1:0]               RISE,
    output logic [N_CH-1:0]               FALL,
    output logic [PRESS_CNT_W*N_CH-1:0]   PRESS_CNT
);

    // One fully independent channel per input pin
    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_LEVEL     (RESET_LEVEL)
        ) u_ch (
            .i_clk       (OSC_FPGA),
            .i_rst       (RST),
            .i_raw       (RAW_IN[g]),
            .o_clean     (CLEAN[g]),
            .o_rise      (RISE[g]),
            .o_fall      (FALL[g]),
            .o_press_cnt (PRESS_CNT[PRESS_CNT_W*g +: PRESS_CNT_W])
        );
    end

endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed bench for input_conditioner with
// DEBOUNCE_CYCLES=4, RESET_LEVEL=0. Press-count expectations follow
// INPUT_COND_PRESS_CNT_EN.
module tb_input_conditioner;

  localparam int N   = 4;
  localparam int DC  = 4;
  localparam int LAT = DC + 2;   // sampling edge to pulse, inclusive

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] raw;
  logic [3:0] clean;
  logic [3:0] rise;
  logic [3:0] fall;
  logic [7:0] press;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  input_conditioner #(
    .N_CH            (N),
    .DEBOUNCE_CYCLES (DC),
    .RESET_LEVEL     (1'b0)
  ) dut (
    .OSC_FPGA  (clk),
    .RST       (rst),
    .RAW_IN    (raw),
    .CLEAN     (clean),
    .RISE      (rise),
    .FALL      (fall),
    .PRESS_CNT (press)
  );

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [3:0] clean_m = 4'b0000;
  logic [1:0] press_m [4];
  // entry: {cycle[35:20], rise[19:16], fall[15:12], clean[11:8], press[7:0]}
  logic [35:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] press_pack();
`ifdef INPUT_COND_PRESS_CNT_EN
    return {press_m[3], press_m[2], press_m[1], press_m[0]};
`else
    return 8'h00;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) press_m[i] = 2'd0;
    clean_m = 4'b0000;
  endtask

  // Drive a qualifying (held) change and predict its pulse
  task automatic change(input logic [3:0] nv);
    logic [3:0] r_m;
    logic [3:0] f_m;
    r_m = nv & ~clean_m;
    f_m = ~nv & clean_m;
    raw = nv;
    clean_m = nv;
    for (int i = 0; i < 4; i++) if (r_m[i]) press_m[i] = press_m[i] + 2'd1;
    if ((r_m | f_m) != 4'b0000)
      exp_q.push_back({16'(cyc + LAT), r_m, f_m, clean_m, press_pack()});
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    model_reset();
    step(n);
    rst = 1'b0;
  endtask

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    logic [35:0] e;
    if ((rise | fall) != 4'b0000) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {24'h0, rise, fall}, 32'h0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_cycle", 32'(cyc), 32'(e[35:20]));
        check("pulse_rise", 32'(rise), 32'(e[19:16]));
        check("pulse_fall", 32'(fall), 32'(e[15:12]));
        check("pulse_clean", 32'(clean), 32'(e[11:8]));
        check("pulse_press", 32'(press), 32'(e[7:0]));
      end
    end else if (exp_q.size() > 0 && 32'(exp_q[0][35:20]) < 32'(cyc)) begin
      e = exp_q.pop_front();
      check("missed_pulse", 32'(cyc), 32'(e[35:20]));
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    raw = 4'b0000;
    model_reset();

    // Reset behaviour: all outputs zero during and after reset
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_hold", {12'h0, clean, rise, fall, press}, 32'h0);
    end
    rst = 1'b0;
    step(1);
    check("reset_release", {12'h0, clean, rise, fall, press}, 32'h0);
    step(2);

    // Clean press on PB0: CLEAN flips exactly LAT edges after sampling
    change(4'b0001);
    step(LAT - 1);
    check("press_before", 32'(clean), 32'h0);
    step(1);
    check("press_after", 32'(clean), 32'h1);
    step(4);
    change(4'b0000);
    step(LAT + 3);
    check("release_clean", 32'(clean), 32'h0);

    // Glitch rejection on PB1: high 3 cycles only
    raw[1] = 1'b1;
    step(3);
    raw[1] = 1'b0;
    step(LAT + 6);
    check("glitch_clean", 32'(clean), 32'h0);

    // Bounce then settle on SW0
    raw[2] = 1'b1; step(1);
    raw[2] = 1'b0; step(1);
    raw[2] = 1'b1; step(1);
    raw[2] = 1'b0; step(1);
    change(4'b0100);
    step(LAT + 3);
    check("bounce_clean", 32'(clean), 32'h4);
    change(4'b0000);
    step(LAT + 3);

    // Press-count wrap on PB0 from a fresh reset
    do_reset(2);
    step(1);
    check("press_cnt_reset", 32'(press), 32'h0);
    for (int i = 0; i < 5; i++) begin
      change(4'b0001);
      step(LAT + 2);
`ifdef INPUT_COND_PRESS_CNT_EN
      check("press_cnt_step", 32'(press[1:0]), 32'((i + 1) % 4));
`else
      check("press_cnt_off", 32'(press), 32'h0);
`endif
      change(4'b0000);
      step(LAT + 2);
    end

    // Reset mid-count on SW1 (counter at 2): no pulse, CLEAN stays 0
    raw[3] = 1'b1;
    step(4);
    rst = 1'b1;
    raw[3] = 1'b0;
    model_reset();
    step(1);
    check("midcount_in_reset", {24'h0, clean, rise | fall}, 32'h0);
    step(1);
    rst = 1'b0;
    step(LAT + 6);
    check("midcount_after", 32'(clean), 32'h0);

    // Parallel channels: PB0 and SW1 rise on the same edge
    change(4'b1001);
    step(LAT + 3);
    check("parallel_clean", 32'(clean), 32'h9);
    change(4'b0000);
    step(LAT + 3);
    check("parallel_release", 32'(clean), 32'h0);

    // Every predicted pulse must have been consumed
    step(LAT + 2);
    check("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard bound on total run time
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
